// File: rtl/instr_loader.sv
// Encodes streamed instruction tuples into RV32I words and writes them to instruction memory.
// Writes are registered one cycle after transfer; in_ready drops outside LOAD or once memory is full.
module instr_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [2:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic              in_funct7,
    input  logic [12:0]       in_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W:0]    count_q, count_d;
    logic               err_q, err_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;

    logic        op_ok;
    logic [31:0] enc_word;
    logic        xfer;

    always_comb begin
        op_ok    = 1'b1;
        enc_word = '0;
        case (in_op)
            3'd0: enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
            3'd1: enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
            3'd2: enc_word = {1'b0, in_funct7, 5'b00000, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
            3'd3: begin
                // Shift-immediates carry funct7 in the upper bits and a 5-bit shamt
                if (in_funct3 == 3'b001 || in_funct3 == 3'b101)
                    enc_word = {1'b0, in_funct7, 5'b00000, in_imm[4:0], in_rs1, in_funct3, in_rd, 7'b0010011};
                else
                    enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
            end
            3'd4: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                              in_imm[4:1], in_imm[11], 7'b1100011};
            default: op_ok = 1'b0;
        endcase
    end

    assign in_ready = (state_q == S_LOAD) && (count_q < MAX_WORDS);
    assign xfer     = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        count_d     = count_q;
        err_d       = err_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_LOAD;
                    addr_d  = '0;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            S_LOAD: begin
                if (count_q == MAX_WORDS) begin
                    state_d = S_DONE;
                end else if (xfer) begin
                    if (op_ok) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = addr_q;
                        mem_wdata_d = enc_word;
                        addr_d      = addr_q + ADDR_W'(1);
                        count_d     = count_q + (ADDR_W+1)'(1);
                        // Memory just filled with no end marker: flag overflow now
                        if (count_d == MAX_WORDS && !in_last)
                            err_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    if (in_last)
                        state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            count_q     <= count_d;
            err_q       <= err_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign count     = count_q;
    assign err       = err_q;
    assign done      = (state_q == S_DONE);
    assign cpu_hold  = (state_q != S_DONE);

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader (ADDR_W=2): directed encodings, invalid op, overflow, reset abort, random sessions.
module tb_instr_loader;

    localparam int AW   = 2;
    localparam int MAXW = 1 << AW;
    localparam int M_IDLE = 0, M_LOAD = 1, M_DONE = 2;

    logic          clk = 1'b0;
    logic          rst, start, in_valid, in_ready, in_last;
    logic [2:0]    in_op;
    logic [4:0]    in_rd, in_rs1, in_rs2;
    logic [2:0]    in_funct3;
    logic          in_funct7;
    logic [12:0]   in_imm;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_hold, done, err;
    logic [AW:0]   count;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: session state, counters and the expected write-port contents
    int          m_state, m_count, m_addr;
    bit          m_err, exp_we;
    int          exp_addr;
    bit [31:0]   exp_data;

    instr_loader #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .done(done), .err(err), .count(count)
    );

    always #5 clk = ~clk;

    function automatic bit [31:0] ref_encode(input int unsigned op, input int unsigned rd,
                                             input int unsigned rs1, input int unsigned rs2,
                                             input int unsigned f3, input int unsigned f7,
                                             input int unsigned imm);
        bit [31:0] base;
        base = (rs1 << 15) + (f3 << 12);
        case (op)
            0: return ((imm % 4096) << 20) + base + (rd << 7) + 3;
            1: return (((imm / 32) % 128) << 25) + (rs2 << 20) + base + ((imm % 32) << 7) + 35;
            2: return (f7 << 30) + (rs2 << 20) + base + (rd << 7) + 51;
            3: if (f3 == 1 || f3 == 5) return (f7 << 30) + ((imm % 32) << 20) + base + (rd << 7) + 19;
               else return ((imm % 4096) << 20) + base + (rd << 7) + 19;
            4: return (((imm / 4096) % 2) << 31) + (((imm / 32) % 64) << 25) + (rs2 << 20) + base
                      + (((imm / 2) % 16) << 8) + (((imm / 2048) % 2) << 7) + 99;
            default: return 0;
        endcase
    endfunction

    function automatic bit exp_ready();
        return (m_state == M_LOAD) && (m_count < MAXW);
    endfunction

    // One clock edge: advance the model from the currently driven inputs, then wait to the falling edge
    task automatic tick();
        exp_we = 0;
        if (rst) begin
            m_state = M_IDLE; m_count = 0; m_addr = 0; m_err = 0; exp_addr = 0; exp_data = 0;
        end else if (m_state != M_LOAD) begin
            if (start) begin m_state = M_LOAD; m_count = 0; m_addr = 0; m_err = 0; end
        end else if (m_count == MAXW) begin
            m_state = M_DONE;
        end else if (in_valid) begin
            if (in_op < 5) begin
                exp_we   = 1;
                exp_addr = m_addr;
                exp_data = ref_encode(in_op, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
                m_addr   = (m_addr + 1) % MAXW;
                m_count++;
                if (m_count == MAXW && !in_last) m_err = 1;
            end else begin
                m_err = 1;
            end
            if (in_last) m_state = M_DONE;
        end
        @(negedge clk);
    endtask

    task automatic set_tuple(input int op, input int rd, input int rs1, input int rs2,
                             input int f3, input int f7, input int imm, input bit last);
        in_op = 3'(op); in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2);
        in_funct3 = 3'(f3); in_funct7 = 1'(f7); in_imm = 13'(imm); in_last = last; in_valid = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(); tick();
        n_cmp++; if (mem_we !== 1'b0)    begin n_bad++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
        n_cmp++; if (mem_addr !== '0)    begin n_bad++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
        n_cmp++; if (mem_wdata !== 32'h0) begin n_bad++; $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); end
        n_cmp++; if (count !== '0)       begin n_bad++; $display("FAIL rst_count: got %0d want 0", count); end
        n_cmp++; if (err !== 1'b0)       begin n_bad++; $display("FAIL rst_err: got %b want 0", err); end
        n_cmp++; if (done !== 1'b0)      begin n_bad++; $display("FAIL rst_done: got %b want 0", done); end
        n_cmp++; if (cpu_hold !== 1'b1)  begin n_bad++; $display("FAIL rst_cpu_hold: got %b want 1", cpu_hold); end
        n_cmp++; if (in_ready !== 1'b0)  begin n_bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        rst = 1'b0; tick();
        n_cmp++; if (in_ready !== 1'b0 || cpu_hold !== 1'b1) begin
            n_bad++; $display("FAIL idle_hold: in_ready %b cpu_hold %b want 0/1", in_ready, cpu_hold); end
    endtask

    task automatic test_itype_store_branch();
        pulse_start();
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL load_ready: got %b want 1", in_ready); end
        set_tuple(3, 1, 0, 0, 0, 0, 5, 0); tick(); in_valid = 1'b0;
        n_cmp++; if (mem_we !== 1'b1 || mem_addr !== 2'd0 || mem_wdata !== 32'h00500093) begin
            n_bad++; $display("FAIL itype_write: we %b addr %0d data %h want 1/0/00500093", mem_we, mem_addr, mem_wdata); end
        n_cmp++; if (count !== 3'd1) begin n_bad++; $display("FAIL itype_count: got %0d want 1", count); end
        set_tuple(1, 0, 2, 5, 2, 0, 12, 0); tick();
        n_cmp++; if (mem_we !== 1'b1 || mem_addr !== 2'd1 || mem_wdata !== 32'h00512623) begin
            n_bad++; $display("FAIL store_write: we %b addr %0d data %h want 1/1/00512623", mem_we, mem_addr, mem_wdata); end
        set_tuple(4, 0, 1, 2, 0, 0, 13'h1FF8, 1); tick(); in_valid = 1'b0;
        n_cmp++; if (mem_we !== 1'b1 || mem_addr !== 2'd2 || mem_wdata !== 32'hFE208CE3) begin
            n_bad++; $display("FAIL branch_write: we %b addr %0d data %h want 1/2/FE208CE3", mem_we, mem_addr, mem_wdata); end
        n_cmp++; if (done !== 1'b1 || count !== 3'd3) begin
            n_bad++; $display("FAIL branch_done: done %b count %0d want 1/3", done, count); end
        tick();
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL we_one_cycle: got %b want 0", mem_we); end
    endtask

    task automatic test_rtype_load();
        pulse_start();
        set_tuple(2, 3, 1, 2, 0, 1, 0, 0); tick();
        n_cmp++; if (mem_we !== 1'b1 || mem_addr !== 2'd0 || mem_wdata !== 32'h402081B3) begin
            n_bad++; $display("FAIL rtype_write: we %b addr %0d data %h want 1/0/402081B3", mem_we, mem_addr, mem_wdata); end
        n_cmp++; if (cpu_hold !== 1'b1 || done !== 1'b0) begin
            n_bad++; $display("FAIL load_hold: cpu_hold %b done %b want 1/0", cpu_hold, done); end
        set_tuple(0, 6, 1, 0, 2, 0, 4, 1); tick(); in_valid = 1'b0;
        n_cmp++; if (mem_we !== 1'b1 || mem_addr !== 2'd1 || mem_wdata !== 32'h0040A303) begin
            n_bad++; $display("FAIL lw_write: we %b addr %0d data %h want 1/1/0040A303", mem_we, mem_addr, mem_wdata); end
        n_cmp++; if (done !== 1'b1 || cpu_hold !== 1'b0 || err !== 1'b0) begin
            n_bad++; $display("FAIL lw_done: done %b cpu_hold %b err %b want 1/0/0", done, cpu_hold, err); end
    endtask

    task automatic test_invalid_op();
        pulse_start();
        set_tuple(6, 1, 1, 1, 0, 0, 0, 1); tick(); in_valid = 1'b0;
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL inv_we: got %b want 0", mem_we); end
        n_cmp++; if (err !== 1'b1 || done !== 1'b1 || count !== 3'd0) begin
            n_bad++; $display("FAIL inv_state: err %b done %b count %0d want 1/1/0", err, done, count); end
        tick();
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL inv_sticky: got %b want 1", err); end
        pulse_start();
        n_cmp++; if (err !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++; $display("FAIL inv_restart: err %b done %b ready %b want 0/0/1", err, done, in_ready); end
    endtask

    task automatic test_overflow();
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            set_tuple($urandom_range(0, 4), $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                      $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 8191), 0);
            n_cmp++; if (in_ready !== (i < 4)) begin
                n_bad++; $display("FAIL ovf_ready_%0d: got %b want %b", i, in_ready, (i < 4)); end
            tick();
            if (i < 4) begin
                n_cmp++; if (mem_we !== 1'b1 || mem_addr !== AW'(i) || mem_wdata !== exp_data) begin
                    n_bad++; $display("FAIL ovf_write_%0d: we %b addr %0d data %h want 1/%0d/%h",
                                      i, mem_we, mem_addr, mem_wdata, i, exp_data); end
            end else begin
                n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL ovf_nowrite: got %b want 0", mem_we); end
            end
        end
        in_valid = 1'b0;
        n_cmp++; if (err !== 1'b1 || done !== 1'b1 || count !== 3'd4) begin
            n_bad++; $display("FAIL ovf_end: err %b done %b count %0d want 1/1/4", err, done, count); end
    endtask

    task automatic test_rst_abort();
        int extra;
        pulse_start();
        set_tuple(2, 7, 3, 4, 0, 0, 0, 0); tick();
        n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL abort_first_write: got %b want 1", mem_we); end
        set_tuple(3, 8, 3, 0, 0, 0, 77, 0);
        rst = 1'b1; tick(); rst = 1'b0;
        n_cmp++; if (mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== 32'h0 || count !== '0) begin
            n_bad++; $display("FAIL abort_mem: we %b addr %0d data %h count %0d want 0/0/0/0",
                              mem_we, mem_addr, mem_wdata, count); end
        n_cmp++; if (err !== 1'b0 || done !== 1'b0 || cpu_hold !== 1'b1 || in_ready !== 1'b0) begin
            n_bad++; $display("FAIL abort_ctl: err %b done %b hold %b ready %b want 0/0/1/0",
                              err, done, cpu_hold, in_ready); end
        extra = 0;
        for (int i = 0; i < 4; i++) begin tick(); if (mem_we === 1'b1) extra++; end
        in_valid = 1'b0;
        n_cmp++; if (extra != 0) begin n_bad++; $display("FAIL abort_writes: got %0d want 0", extra); end
    endtask

    task automatic test_random();
        int len;
        for (int s = 0; s < 30; s++) begin
            pulse_start();
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                set_tuple(($urandom_range(0, 7) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4),
                          $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                          $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 8191), (i == len - 1));
                start = (m_state == M_LOAD) && ($urandom_range(0, 5) == 0);
                n_cmp++; if (in_ready !== exp_ready()) begin
                    n_bad++; $display("FAIL rnd_ready s%0d t%0d: got %b want %b", s, i, in_ready, exp_ready()); end
                tick();
                start = 1'b0;
                n_cmp++; if (mem_we !== exp_we) begin
                    n_bad++; $display("FAIL rnd_we s%0d t%0d: got %b want %b", s, i, mem_we, exp_we); end
                if (exp_we) begin
                    n_cmp++; if (mem_addr !== AW'(exp_addr) || mem_wdata !== exp_data) begin
                        n_bad++; $display("FAIL rnd_word s%0d t%0d: addr %0d data %h want %0d/%h",
                                          s, i, mem_addr, mem_wdata, exp_addr, exp_data); end
                end
                n_cmp++; if (count !== (AW+1)'(m_count) || err !== m_err) begin
                    n_bad++; $display("FAIL rnd_cnt s%0d t%0d: count %0d err %b want %0d/%b",
                                      s, i, count, err, m_count, m_err); end
            end
            in_valid = 1'b0;
            tick();
            n_cmp++; if (done !== 1'b1 || cpu_hold !== 1'b0 || err !== m_err || count !== (AW+1)'(m_count)) begin
                n_bad++; $display("FAIL rnd_end s%0d: done %b hold %b err %b count %0d want 1/0/%b/%0d",
                                  s, done, cpu_hold, err, count, m_err, m_count); end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_op = '0; in_rd = '0;
        in_rs1 = '0; in_rs2 = '0; in_funct3 = '0; in_funct7 = 1'b0; in_imm = '0;
        m_state = M_IDLE; m_count = 0; m_addr = 0; m_err = 0; exp_we = 0; exp_addr = 0; exp_data = 0;
        @(negedge clk);
        test_reset();
        test_itype_store_branch();
        test_rtype_load();
        test_invalid_op();
        test_overflow();
        test_rst_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
